// File: rtl/bot_mbox_pkg.sv
// bot_mbox_pkg: shared constants and types for the per-bot velocity mailbox protocol
package bot_mbox_pkg;
  localparam logic [7:0] MB_FLAG_R = 8'h72;
  localparam logic [7:0] MB_FLAG_W = 8'h77;
  localparam int MB_STRIDE = 4;
  localparam int MB_OFF_FLAG = 0;
  localparam int MB_OFF_VX = 1;
  localparam int MB_OFF_VY = 2;
  typedef logic signed [31:0] q16_16_t;
  typedef enum logic [2:0] {FLAG_RD, FLAG_CHK, VX_RD, VY_RD, VY_CAP, OUT, CLR, GAP} mb_state_e;
  function automatic logic [3:0] next_idx(input logic [3:0] idx, input int num);
    return 32'(idx) == num - 1 ? 4'd0 : idx + 4'd1;
  endfunction
endpackage

// File: rtl/bot_mailbox_reader.sv
// bot_mailbox_reader: round-robin mailbox poller that turns 'w' slots into velocity commands
module bot_mailbox_reader
  import bot_mbox_pkg::*;
#(
  parameter int NUM_BOTS = 3,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 6,
  parameter int POLL_GAP = 4,
  parameter logic [7:0] FLAG_R = MB_FLAG_R,
  parameter logic [7:0] FLAG_W = MB_FLAG_W
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] mb_addr,
  output logic              mb_rd_en,
  input  logic [DATA_W-1:0] mb_rdata,
  output logic              mb_wr_en,
  output logic [DATA_W-1:0] mb_wdata,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [3:0]        cmd_bot_id,
  output logic [DATA_W-1:0] cmd_vx,
  output logic [DATA_W-1:0] cmd_vy,
  output logic              bad_flag,
  output logic [15:0]       bad_count
);
  mb_state_e state, state_nx, to_gap;
  logic [3:0] bot_idx;
  logic [15:0] gap_cnt;
  logic [7:0] flag;
  logic [ADDR_W-1:0] base;
  logic is_bad, gap_done, leave;
  assign flag = mb_rdata[7:0];
  assign base = ADDR_W'(32'(bot_idx) * MB_STRIDE);
  assign to_gap = POLL_GAP == 0 ? FLAG_RD : GAP;
  assign is_bad = state == FLAG_CHK && flag != FLAG_R && flag != FLAG_W;
  assign gap_done = state == GAP && gap_cnt == 16'(POLL_GAP - 1);
  // with no gap the slot index advances straight out of FLAG_CHK or CLR
  assign leave = gap_done || (POLL_GAP == 0 && (state == CLR || (state == FLAG_CHK && flag != FLAG_W)));
  assign cmd_valid = !rst && state == OUT;
  assign bad_flag = !rst && is_bad;
  always_comb begin
    state_nx = state;
    mb_rd_en = 1'b0;
    mb_wr_en = 1'b0;
    mb_addr = '0;
    mb_wdata = '0;
    if (!rst)
      case (state)
        FLAG_RD: begin
          mb_rd_en = 1'b1;
          mb_addr = base + ADDR_W'(MB_OFF_FLAG);
          state_nx = FLAG_CHK;
        end
        FLAG_CHK: state_nx = flag == FLAG_W ? VX_RD : to_gap;
        VX_RD: begin
          mb_rd_en = 1'b1;
          mb_addr = base + ADDR_W'(MB_OFF_VX);
          state_nx = VY_RD;
        end
        VY_RD: begin
          mb_rd_en = 1'b1;
          mb_addr = base + ADDR_W'(MB_OFF_VY);
          state_nx = VY_CAP;
        end
        VY_CAP: state_nx = OUT;
        OUT: state_nx = cmd_ready ? CLR : OUT;
        CLR: begin
          mb_wr_en = 1'b1;
          mb_addr = base + ADDR_W'(MB_OFF_FLAG);
          mb_wdata = DATA_W'(FLAG_R);
          state_nx = to_gap;
        end
        GAP: state_nx = gap_done ? FLAG_RD : GAP;
        default: state_nx = FLAG_RD;
      endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FLAG_RD;
      bot_idx <= '0;
      gap_cnt <= '0;
      cmd_bot_id <= '0;
      cmd_vx <= '0;
      cmd_vy <= '0;
      bad_count <= '0;
    end else begin
      state <= state_nx;
      gap_cnt <= state == GAP ? gap_cnt + 16'd1 : 16'd0;
      if (leave) bot_idx <= next_idx(bot_idx, NUM_BOTS);
      if (state == VY_RD) cmd_vx <= mb_rdata;
      if (state == VY_CAP) begin
        cmd_vy <= mb_rdata;
        cmd_bot_id <= bot_idx;
      end
      if (is_bad && bad_count != 16'hFFFF) bad_count <= bad_count + 16'd1;
    end
  end
endmodule

// File: tb/tb_bot_mailbox_reader.sv
// tb_bot_mailbox_reader: mailbox RAM model, protocol-level scoreboard and directed scenarios
module tb_bot_mailbox_reader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [5:0] mb_addr;
  logic mb_rd_en, mb_wr_en, cmd_valid, bad_flag;
  logic cmd_ready = 1'b0;
  logic [31:0] mb_rdata, mb_wdata, cmd_vx, cmd_vy;
  logic [3:0] cmd_bot_id;
  logic [15:0] bad_count;

  bot_mailbox_reader dut (
    .clk(clk), .rst(rst), .mb_addr(mb_addr), .mb_rd_en(mb_rd_en), .mb_rdata(mb_rdata),
    .mb_wr_en(mb_wr_en), .mb_wdata(mb_wdata), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_bot_id(cmd_bot_id), .cmd_vx(cmd_vx), .cmd_vy(cmd_vy), .bad_flag(bad_flag),
    .bad_count(bad_count)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0, cyc = 0, valid_seen = 0;
  logic [31:0] mem [64];
  logic ld_en = 1'b0;
  logic [5:0] ld_addr = '0;
  logic [31:0] ld_data = '0;

  // synchronous-read mailbox RAM; the bench preloads it through its own write port
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mb_rd_en) mb_rdata <= mem[mb_addr];
    if (mb_wr_en) mem[mb_addr] <= mb_wdata;
    if (ld_en) mem[ld_addr] <= ld_data;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h required=%h", name, got, exp);
    end
  endtask

  typedef struct { int id; logic [31:0] vx; logic [31:0] vy; } cmd_t;
  cmd_t q[$];
  int vis_cyc[$], vis_addr[$], wr_log[$], tx_ids[$];
  int exp_idx = 0, clr_addr = 0;
  bit exp_bad = 0, clr_pend = 0;
  logic [15:0] exp_cnt = '0;
  logic [7:0] f;

  // protocol model: every 'w' flag read owes one command with the slot's stored
  // words, each transfer owes one 'r' write next cycle, each odd flag owes a pulse
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      exp_idx = 0;
      exp_cnt = '0;
      exp_bad = 0;
      clr_pend = 0;
    end else begin
      chk("one_strobe", 32'(mb_rd_en & mb_wr_en), 0);
      if (!mb_rd_en && !mb_wr_en) chk("idle_addr", 32'(mb_addr), 0);
      else chk("reserved_word", 32'(mb_addr[1:0] == 2'd3), 0);
      chk("bad_flag", 32'(bad_flag), 32'(exp_bad));
      chk("bad_count", 32'(bad_count), 32'(exp_cnt));
      chk("clr_strobe", 32'(mb_wr_en), 32'(clr_pend));
      if (mb_wr_en) begin
        chk("clr_addr", 32'(mb_addr), clr_addr);
        chk("clr_data", mb_wdata, 32'h72);
        wr_log.push_back(int'(mb_addr));
      end
      clr_pend = 0;
      if (cmd_valid) begin
        valid_seen++;
        chk("valid_no_access", 32'(mb_rd_en | mb_wr_en), 0);
        chk("cmd_expected", 32'(q.size() > 0), 1);
        if (q.size() > 0) begin
          chk("cmd_id", 32'(cmd_bot_id), q[0].id);
          chk("cmd_vx", cmd_vx, q[0].vx);
          chk("cmd_vy", cmd_vy, q[0].vy);
          if (cmd_ready) begin
            clr_pend = 1;
            clr_addr = q[0].id * 4;
            tx_ids.push_back(q[0].id);
            void'(q.pop_front());
          end
        end
      end
      if (exp_bad && exp_cnt != 16'hFFFF) exp_cnt++;
      exp_bad = 0;
      if (mb_rd_en && mb_addr[1:0] == 2'd0) begin
        f = mem[mb_addr][7:0];
        chk("visit_slot", 32'(mb_addr[5:2]), exp_idx);
        exp_idx = (exp_idx + 1) % 3;
        vis_cyc.push_back(cyc);
        vis_addr.push_back(int'(mb_addr));
        exp_bad = f != 8'h72 && f != 8'h77;
        if (f == 8'h77) q.push_back('{int'(mb_addr[5:2]), mem[mb_addr + 6'd1], mem[mb_addr + 6'd2]});
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic poke(input int a, input logic [31:0] d);
    ld_addr = 6'(a);
    ld_data = d;
    ld_en = 1'b1;
    @(posedge clk);
    #1 ld_en = 1'b0;
  endtask

  task automatic load(input int s, input logic [7:0] fl, input logic [31:0] vx, input logic [31:0] vy);
    poke(s * 4, {24'h0, fl});
    poke(s * 4 + 1, vx);
    poke(s * 4 + 2, vy);
  endtask

  task automatic start(input logic [7:0] f0, input logic [7:0] f1, input logic [7:0] f2, input logic rdy);
    @(posedge clk);
    #1 rst = 1'b1;
    cmd_ready = rdy;
    load(0, f0, 32'h00010000, 32'hFFFF0000);
    load(1, f1, 32'h0000028F, 32'h00000A3D);
    load(2, f2, 32'h00008000, 32'hFFFFC000);
    vis_cyc.delete();
    vis_addr.delete();
    wr_log.delete();
    tx_ids.delete();
    valid_seen = 0;
    step();
    chk("rst_valid", 32'(cmd_valid), 0);
    chk("rst_rd", 32'(mb_rd_en), 0);
    chk("rst_wr", 32'(mb_wr_en), 0);
    chk("rst_addr", 32'(mb_addr), 0);
    chk("rst_bad_count", 32'(bad_count), 0);
    chk("rst_vx", cmd_vx, 0);
    chk("rst_id", 32'(cmd_bot_id), 0);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_valid(input string nm);
    for (int i = 0; i < 60 && !cmd_valid; i++) step();
    chk(nm, 32'(cmd_valid), 1);
  endtask

  int stable;

  initial begin
    // all slots free: pure polling, 6 cycles per visit, no commands, no writes
    start(8'h72, 8'h72, 8'h72, 1'b0);
    for (int i = 0; i < 40 && vis_addr.size() < 4; i++) step();
    chk("s1_visits", vis_addr.size(), 4);
    if (vis_addr.size() >= 4) begin
      chk("s1_addr0", vis_addr[0], 0);
      chk("s1_addr1", vis_addr[1], 4);
      chk("s1_addr2", vis_addr[2], 8);
      chk("s1_addr3", vis_addr[3], 0);
      for (int i = 1; i < 4; i++) chk("s1_spacing", vis_cyc[i] - vis_cyc[i - 1], 6);
    end
    chk("s1_writes", wr_log.size(), 0);
    chk("s1_no_valid", valid_seen, 0);

    // slot 1 fresh, consumer always ready
    start(8'h72, 8'h77, 8'h72, 1'b1);
    wait_valid("s2_valid");
    if (vis_addr.size() >= 2) begin
      chk("s2_visit_addr", vis_addr[1], 4);
      chk("s2_latency", cyc - vis_cyc[1], 5);
    end
    chk("s2_id", 32'(cmd_bot_id), 1);
    chk("s2_vx", cmd_vx, 32'h0000028F);
    chk("s2_vy", cmd_vy, 32'h00000A3D);
    step();
    chk("s2_clr_wr", 32'(mb_wr_en), 1);
    chk("s2_clr_addr", 32'(mb_addr), 4);
    chk("s2_clr_data", mb_wdata, 32'h72);
    chk("s2_valid_drop", 32'(cmd_valid), 0);
    step();
    chk("s2_flag_r", mem[4], 32'h72);

    // slot 1 fresh, consumer stalls 20 cycles
    start(8'h72, 8'h77, 8'h72, 1'b0);
    wait_valid("s3_valid");
    stable = 0;
    for (int i = 0; i < 20; i++) begin
      if (cmd_valid && cmd_bot_id == 4'd1 && cmd_vx == 32'h0000028F && cmd_vy == 32'h00000A3D && !mb_rd_en && !mb_wr_en) stable++;
      step();
    end
    chk("s3_stable", stable, 20);
    @(posedge clk);
    #1 cmd_ready = 1'b1;
    step();
    step();
    chk("s3_clr_wr", 32'(mb_wr_en), 1);
    repeat (3) step();
    chk("s3_one_write", wr_log.size(), 1);
    if (wr_log.size() > 0) chk("s3_write_addr", wr_log[0], 4);

    // slot 2 holds a corrupt flag
    start(8'h72, 8'h72, 8'h00, 1'b1);
    for (int k = 1; k <= 3; k++) begin
      for (int i = 0; i < 60 && !bad_flag; i++) step();
      chk("s4_bad_pulse", 32'(bad_flag), 1);
      if (vis_addr.size() > 0) chk("s4_bad_slot", vis_addr[vis_addr.size() - 1], 8);
      step();
      chk("s4_pulse_end", 32'(bad_flag), 0);
      chk("s4_bad_count", 32'(bad_count), k);
    end
    chk("s4_no_write", wr_log.size(), 0);
    chk("s4_flag_kept", mem[8], 32'h0);

    // every slot fresh: commands in slot order, each slot cleared once
    start(8'h77, 8'h77, 8'h77, 1'b1);
    for (int i = 0; i < 200 && tx_ids.size() < 3; i++) step();
    chk("s5_transfers", tx_ids.size(), 3);
    if (tx_ids.size() >= 3)
      for (int i = 0; i < 3; i++) chk("s5_order", tx_ids[i], i);
    repeat (2) step();
    chk("s5_writes", wr_log.size(), 3);
    if (wr_log.size() >= 3)
      for (int i = 0; i < 3; i++) chk("s5_write_addr", wr_log[i], i * 4);
    for (int i = 0; i < 3; i++) chk("s5_flag_r", mem[i * 4], 32'h72);

    // reset while presenting slot 0: the slot must survive and be re-presented
    start(8'h77, 8'h72, 8'h72, 1'b0);
    wait_valid("s6_valid");
    chk("s6_id", 32'(cmd_bot_id), 0);
    @(posedge clk);
    #1 rst = 1'b1;
    step();
    chk("s6_valid_drop", 32'(cmd_valid), 0);
    chk("s6_flag_kept", mem[0], 32'h77);
    @(posedge clk);
    #1 rst = 1'b0;
    wait_valid("s6_revalid");
    chk("s6_re_id", 32'(cmd_bot_id), 0);
    chk("s6_re_vx", cmd_vx, 32'h00010000);
    chk("s6_re_vy", cmd_vy, 32'hFFFF0000);
    @(posedge clk);
    #1 cmd_ready = 1'b1;
    step();
    step();
    chk("s6_clr_wr", 32'(mb_wr_en), 1);
    chk("s6_clr_addr", 32'(mb_addr), 0);
    step();
    chk("s6_flag_r", mem[0], 32'h72);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
